fnd_scan_ctrl: RTL and testbench

//  Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
//  - Snapshots a 16-bit hex value once per frame and steps through its nibbles.
//  - Presents the current nibble to the hex-to-segment decoder and registers the returned pattern.
//  - Drives active-low segments, anodes and decimal point, with an anode-off guard interval per digit to suppress ghosting.

---
 rtl/fnd_scan_ctrl.sv | 94 +++++++++
 tb/tb_fnd_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Optional leading-zero suppression: define FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  digit_nib,
  input  logic [6:0]  seg_d,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_tick
);

  localparam int              CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic [3:0]       dp_sh;

  logic slot_end;
  logic frame_start;
  logic guard;
  logic suppress;

  // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    slot_end    = (cnt == CNT_LAST);
    frame_start = (cnt == '0) && (idx == 2'd0);
    guard       = (cnt < CNT_BLANK);
    digit_nib   = shadow[{idx, 2'b00} +: 4];
    suppress    = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
    // A digit goes dark only if it and every more-significant digit are zero with no dp.
    unique case (idx)
      2'd1:    suppress = (shadow[15:4]  == 12'h000) && !dp_sh[1];
      2'd2:    suppress = (shadow[15:8]  == 8'h00)   && !dp_sh[2];
      2'd3:    suppress = (shadow[15:12] == 4'h0)    && !dp_sh[3];
      default: suppress = 1'b0;
    endcase
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      dp_sh      <= 4'h0;
      an_n       <= 4'hF;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      cnt        <= '0;
      idx        <= 2'd0;
      an_n       <= 4'hF;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      idx        <= slot_end ? idx + 2'd1 : idx;
      frame_tick <= slot_end && (idx == 2'd3);

      // One snapshot per frame keeps all four digits consistent.
      if (frame_start) begin
        shadow <= value;
        dp_sh  <= dp_in;
      end

      // Guard interval also covers the snapshot cycle, so freshly loaded data is never shown early.
      if (guard || suppress) begin
        an_n  <= 4'hF;
        seg_n <= 7'h7F;
        dp_n  <= 1'b1;
      end else begin
        an_n  <= ~(4'b0001 << idx);
        seg_n <= ~seg_d;
        dp_n  <= ~dp_sh[idx];
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl with an external hex decoder and a frame-position reference model.
module tb_fnd_scan_ctrl;

  localparam int SD = 8;
  localparam int BL = 2;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] value  = 16'h0000;
  logic [3:0]  dp_in  = 4'h0;
  logic [3:0]  digit_nib;
  logic [6:0]  seg_d;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the scan since the last restart, plus the frame snapshot.
  int          m_pos;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_ft;

  int ft_seen, dp_low, dp_low_bad, lit_other;

  fnd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .value     (value),
    .dp_in     (dp_in),
    .digit_nib (digit_nib),
    .seg_d     (seg_d),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h27;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  assign seg_d = hex7(digit_nib);

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    return 4'((v >> (4 * d)) & 16'h000F);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_sh  = 16'h0000;
    m_dp  = 4'h0;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_ft  = 1'b0;
  endtask

  // One clock: predict from pre-edge state and inputs, then compare #1 after the edge.
  task automatic step();
    int   slot;
    int   c;
    logic supp;
    if (reset) begin
      model_reset();
    end else if (!enable) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
      m_pos = 0;
    end else begin
      slot = (m_pos / SD) % 4;
      c    = m_pos % SD;
      if (m_pos % (4 * SD) == 0) begin
        m_sh = value;
        m_dp = dp_in;
      end
      supp = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
      supp = (slot != 0) && ((m_sh >> (4 * slot)) == 16'h0000) && !m_dp[slot];
`endif
      if (c < BL || supp) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(4'b0001 << slot);
        e_seg = ~hex7(nib(m_sh, slot));
        e_dp  = ~m_dp[slot];
      end
      e_ft = (c == SD - 1) && (slot == 3);
      m_pos++;
    end
    @(posedge clk);
    #1;
    check("an_n", 32'(an_n), 32'(e_an));
    check("seg_n", 32'(seg_n), 32'(e_seg));
    check("dp_n", 32'(dp_n), 32'(e_dp));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
    check("digit_nib", 32'(digit_nib), 32'(nib(m_sh, (m_pos / SD) % 4)));
    check("one_anode", 32'($countones(~an_n) <= 1), 32'd1);
    if (frame_tick) ft_seen++;
    if (!dp_n) begin
      dp_low++;
      if (an_n != 4'b1011) dp_low_bad++;
    end
    if (an_n != 4'hF && an_n != 4'b1110) lit_other++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic align(input int p);
    int g = 0;
    while (m_pos % (4 * SD) != p && g < 100) begin
      step();
      g++;
    end
    check("align_reached", 32'(m_pos % (4 * SD)), 32'(p));
  endtask

  task automatic check_dark_now(input string tag);
    check({tag, "_an"}, 32'(an_n), 32'hF);
    check({tag, "_seg"}, 32'(seg_n), 32'h7F);
    check({tag, "_dp"}, 32'(dp_n), 32'd1);
    check({tag, "_ft"}, 32'(frame_tick), 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] mask;

    // Async reset assertion takes effect before any clock edge
    #1 reset = 1'b1;
    #1 check_dark_now("rst_async");
    model_reset();
    run(2);

    // Release: first lit cycle is digit 0 at cnt=BL, one cycle later
    reset = 1'b0; enable = 1'b1; value = 16'h1234; dp_in = 4'h0;
    n = 0;
    do begin
      step();
      n++;
    end while (an_n == 4'hF && n < 20);
    check("first_lit_cycle", 32'(n), 32'd3);
    check("first_lit_an", 32'(an_n), 32'b1110);
    check("first_lit_seg", 32'(seg_n), 32'h19);

    // Slot order and one frame_tick per frame
    align(0);
    ft_seen = 0;
    run(4 * SD);
    check("ticks_per_frame", 32'(ft_seen), 32'd1);

    // Decimal point only on digit 2, only outside guard cycles
    dp_in = 4'b0100;
    dp_low = 0; dp_low_bad = 0;
    run(4 * SD);
    check("dp_lit_cycles", 32'(dp_low), 32'(SD - BL));
    check("dp_wrong_slot", 32'(dp_low_bad), 32'd0);

    // Value change mid-frame does not tear the current frame
    align(2 * SD + BL + 1);
    value = 16'hABCD;
    align(3 * SD + BL);
    step();
    check("no_tear_an", 32'(an_n), 32'b0111);
    check("no_tear_seg", 32'(seg_n), 32'h79);
    align(0);
    run(3);
    check("new_frame_an", 32'(an_n), 32'b1110);
    check("new_frame_seg", 32'(seg_n), 32'h21);

    // Disable during digit 1, then re-enable with a fresh snapshot
    align(SD + BL + 2);
    enable = 1'b0;
    step();
    check("disable_dark", 32'(an_n), 32'hF);
    run(3);
    value = 16'h5678; enable = 1'b1;
    step();
    value = 16'hFFFF;
    run(2);
    check("reenable_an", 32'(an_n), 32'b1110);
    check("reenable_seg", 32'(seg_n), 32'h00);

    // Reset mid-slot while a digit is lit
    value = 16'h1234; dp_in = 4'h0;
    align(SD + 4);
    #2 reset = 1'b1;
    #1 check_dark_now("rst_mid");
    model_reset();
    step();
    reset = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (an_n == 4'hF && n < 20);
    check("restart_lit_cycle", 32'(n), 32'd3);
    check("restart_lit_an", 32'(an_n), 32'b1110);

    // Leading zeros: suppressed only when the option is built in
    value = 16'h0007; dp_in = 4'h0;
    align(0);
    lit_other = 0;
    run(4 * SD);
`ifdef FND_LEADING_ZERO_BLANK_EN
    check("lz_other_digits", 32'(lit_other), 32'd0);
`else
    check("lz_other_digits", 32'(lit_other), 32'(3 * (SD - BL)));
`endif

    // Randomized traffic against the model
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 4))
          0:       mask = 16'hFFFF;
          1:       mask = 16'h0FFF;
          2:       mask = 16'h00FF;
          3:       mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        value = 16'($urandom) & mask;
        dp_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      end
      if ($urandom_range(0, 79) == 0) enable = ~enable;
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
